// File: rtl/iter_accum_pkg.sv
// iter_accum_pkg: shared definitions for the iterative accumulation datapath.
//   - Mode encodings (sum / unsigned max / unsigned min; 2'b11 behaves as sum).
//   - Control FSM state encoding.
//   - Helper that selects the fold identity for a mode (all-ones only for min).
package iter_accum_pkg;

  localparam logic [1:0] MODE_SUM = 2'b00;
  localparam logic [1:0] MODE_MAX = 2'b01;
  localparam logic [1:0] MODE_MIN = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The fold identity is 0 for sum and max, and all-ones for min.
  // Callers expand the returned bit to any width with {WIDTH{bit}}.
  function automatic logic identity_is_ones(input logic [1:0] mode);
    return (mode == MODE_MIN);
  endfunction

endpackage

// File: rtl/iter_accum_alu.sv
// iter_accum_alu: combinational fold step, next_acc = op(acc, s_data).
//   mode     in  : fold operation (MODE_SUM / MODE_MAX / MODE_MIN, 11 = sum)
//   acc      in  : current accumulator
//   s_data   in  : incoming sample
//   next_acc out : folded value
//   carry    out : carry out of the WIDTH-bit sum (0 for max/min)
// Build option: ACC_SAT_EN -- when defined, a sum carry clamps next_acc to
// all-ones instead of wrapping. A saturated accumulator stays saturated
// because any further non-zero addend carries again.
module iter_accum_alu
  import iter_accum_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] s_data,
  output logic [WIDTH-1:0] next_acc,
  output logic             carry
);

  logic [WIDTH:0] sum_ext;
  assign sum_ext = {1'b0, acc} + {1'b0, s_data};

  always_comb begin
    next_acc = acc;
    carry    = 1'b0;
    case (mode)
      // Ties keep the current accumulator.
      MODE_MAX: if (s_data > acc) next_acc = s_data;
      MODE_MIN: if (s_data < acc) next_acc = s_data;
      default: begin
        carry = sum_ext[WIDTH];
`ifdef ACC_SAT_EN
        next_acc = sum_ext[WIDTH] ? {WIDTH{1'b1}} : sum_ext[WIDTH-1:0];
`else
        next_acc = sum_ext[WIDTH-1:0];
`endif
      end
    endcase
  end

endmodule

// File: rtl/iter_accum_dp.sv
// iter_accum_dp: folds N samples into one result (sum / max / min).
//   clk, rst_n        : clock, asynchronous active-low reset
//   start/count/mode  : run request, sampled only while ready (IDLE)
//   s_valid/s_data    : sample stream in; s_ready high only in ACCUM
//   result            : final value, held until the next run completes
//   result_valid      : one-cycle pulse when result updates
//   ready             : high in IDLE
//   iter              : samples accepted in the current run
//   overflow          : sticky sum carry for the current run, cleared on start
// Build option: ACC_SAT_EN (see iter_accum_alu) selects saturating sums.
// FSM: IDLE -> ACCUM (count>0) or DONE (count==0); ACCUM -> DONE on the
// last accepted sample; DONE lasts one cycle and registers the result.
module iter_accum_dp
  import iter_accum_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [1:0]       mode,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             ready,
  output logic [CNT_W-1:0] iter,
  output logic             overflow
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;

  logic [WIDTH-1:0] alu_acc;
  logic             alu_carry;

  iter_accum_alu #(.WIDTH(WIDTH)) u_alu (
    .mode     (mode_q),
    .acc      (acc_q),
    .s_data   (s_data),
    .next_acc (alu_acc),
    .carry    (alu_carry)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mode_d         = mode_q;
    acc_d          = acc_q;
    iter_d         = iter_q;
    overflow_d     = overflow_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d      = count;
          mode_d     = mode;
          iter_d     = '0;
          overflow_d = 1'b0;
          acc_d      = {WIDTH{identity_is_ones(mode)}};
          state_d    = (count == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (s_valid) begin
          acc_d      = alu_acc;
          iter_d     = iter_q + 1'b1;
          overflow_d = overflow_q | alu_carry;
          // cnt_q is non-zero here, so cnt_q - 1 cannot underflow.
          if (iter_q == cnt_q - 1'b1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d       = acc_q;
        result_valid_d = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      mode_q         <= MODE_SUM;
      acc_q          <= '0;
      iter_q         <= '0;
      overflow_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mode_q         <= mode_d;
      acc_q          <= acc_d;
      iter_q         <= iter_d;
      overflow_q     <= overflow_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // Handshake outputs decode straight from the state flop.
  assign ready        = (state_q == ST_IDLE);
  assign s_ready      = (state_q == ST_ACCUM);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign iter         = iter_q;
  assign overflow     = overflow_q;

endmodule

// File: doc/iter_accum_dp.md
Name: iter_accum_dp

Overview:
Parametrised successor to the fixed 32-bit ASM-chart accumulation datapath. Folds a stream of N input samples into one result (sum, max or min) under a start/ready handshake. The loop counter and the control FSM are internal. Sits between the ASM control front-end and the result consumer; replaces hand-wired enable lines with a valid/ready sample interface.

Parameters:
WIDTH, 32, sample and result width in bits
CNT_W, 8, width of iteration count; max N = 2^CNT_W - 1

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request new run; sampled only in IDLE
count  in  CNT_W  number of samples N, latched on accepted start
mode  in  2  00 sum, 01 unsigned max, 10 unsigned min, 11 reserved (treated as sum); latched on start
s_valid  in  1  sample valid
s_data  in  WIDTH  sample value
s_ready  out  1  sample accepted when s_valid & s_ready
result  out  WIDTH  final value, held until next accepted start
result_valid  out  1  one-cycle pulse when result updates
ready  out  1  high in IDLE (can accept start)
iter  out  CNT_W  samples accepted in current run
overflow  out  1  sum wrapped/saturated during the run; cleared on start

Behaviour:
- Reset (async, rst_n=0): state IDLE; result=0, result_valid=0, ready=1, s_ready=0, iter=0, overflow=0; internal accumulator and latched count/mode cleared.
- States: IDLE, ACCUM, DONE.
- IDLE: ready=1, s_ready=0. start=1 -> latch count, mode; iter<=0; overflow<=0; acc<=identity (sum 0, max 0, min all-ones). If count==0 -> DONE; else -> ACCUM.
- ACCUM: ready=0, s_ready=1. Per accepted sample: acc<=op(acc,s_data); iter<=iter+1. Accepting sample with iter==count-1 -> DONE. No accept -> hold all state. start ignored.
- DONE (exactly 1 cycle): result<=acc (registered, visible the cycle after entry with result_valid=1 coincident); -> IDLE. s_ready=0, ready=0.
- Latency: result_valid asserts 2 cycles after the final accepted sample's clock edge; count==0 run: result_valid 2 cycles after start, result=0 for every mode except min (all-ones).
- Sum arithmetic: WIDTH+1-bit add; carry out sets overflow (sticky); result wraps mod 2^WIDTH.
- Max/min: unsigned compare; ties keep current acc; overflow stays 0.
- start and s_valid in same IDLE cycle: sample not accepted (s_ready=0).
- Reset mid-run: run aborted immediately, all outputs to reset values; no result_valid.
- iter never exceeds count; cannot wrap within a run.

Optional Feature:
ACC_SAT_EN: defined -> sum saturates at 2^WIDTH-1 on carry-out and stays saturated for the rest of the run; overflow set identically. Undefined -> wrap-around as above. Max/min unaffected.

Decomposition:
- Package iter_accum_pkg: mode encodings (MODE_SUM, MODE_MAX, MODE_MIN), state enum (ST_IDLE, ST_ACCUM, ST_DONE), identity constants as functions of WIDTH.
- One combinational sub-module iter_accum_alu(mode, acc, s_data -> next_acc, carry), saturation logic under ACC_SAT_EN. FSM, counter and registers stay in the top.

Test Plan:
- Sum, N=4, samples 1,2,3,4 back-to-back -> result=10, result_valid one pulse, overflow=0, iter=4 at DONE.
- Max/min, N=3, samples 5,0xFFFF_FFF0,7 -> max run result=0xFFFF_FFF0; min run result=5.
- Sum overflow, WIDTH=32, N=2, samples 0xFFFF_FFFF,2 -> result=1, overflow=1; with ACC_SAT_EN result=0xFFFF_FFFF, overflow=1.
- count=0, start in any mode -> no s_ready, result_valid 2 cycles after start, result=0 (min: 0xFFFF_FFFF).
- Gapped s_valid (1-cycle bubbles) plus start pulses during ACCUM -> bubbles hold state, starts ignored, sum of N=3 {4,4,4}=12.
- rst_n low after 2 of 4 samples -> outputs reset at once, no result_valid; new run N=1 sample 9 -> result=9.
